race_light_monitor: RTL



---
 rtl/race_light_monitor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/race_light_monitor.sv
// race_light_monitor
//   Track-side consumer of the race-light lamps. Follows the RED -> YELLOW ->
//   GREEN sequence and measures the racer's reaction time in clock cycles from
//   the first GREEN edge to the first LAUNCH edge. It also flags jump starts,
//   no-shows and illegal lamp patterns or orderings.
//
//   Every output is registered. An event sampled at edge k produces its pulse
//   during the cycle after edge k.
//
// Ports
//   CLOCK     in   system clock, rising-edge sampled
//   RESET     in   synchronous, active-high reset
//   RED       in   red lamp
//   YELLOW    in   yellow lamp
//   GREEN     in   green lamp
//   LAUNCH    in   racer launch, level
//   REACTION  out  last valid reaction count, held between results
//   VALID     out  1-cycle pulse: REACTION updated
//   FOUL      out  1-cycle pulse: LAUNCH while YELLOW
//   TIMEOUT   out  1-cycle pulse: no LAUNCH by MAX_REACT
//   SEQ_ERR   out  1-cycle pulse: illegal lamp pattern or order
//   STATE_DBG out  current FSM state (IDLE=0, ARMED=1, TIMING=2, LOCKOUT=3)
module race_light_monitor #(
  parameter int CNT_W     = 8,
  parameter int MAX_REACT = 200
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             RED,
  input  logic             YELLOW,
  input  logic             GREEN,
  input  logic             LAUNCH,
  output logic [CNT_W-1:0] REACTION,
  output logic             VALID,
  output logic             FOUL,
  output logic             TIMEOUT,
  output logic             SEQ_ERR,
  output logic [1:0]       STATE_DBG
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TIMING  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] reaction_n;
  logic             valid_n, foul_n, timeout_n, seq_err_n;
  logic             lamps_legal;

  // Exactly one lamp lit. Anything else is illegal, and illegality overrides
  // every other decision in every state.
  assign lamps_legal = ({RED, YELLOW, GREEN} == 3'b100) ||
                       ({RED, YELLOW, GREEN} == 3'b010) ||
                       ({RED, YELLOW, GREEN} == 3'b001);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    reaction_n = REACTION;
    valid_n    = 1'b0;
    foul_n     = 1'b0;
    timeout_n  = 1'b0;
    seq_err_n  = 1'b0;

    if (!lamps_legal) begin
      seq_err_n = 1'b1;
      state_n   = LOCKOUT;
    end else begin
      case (state)
        IDLE: begin
          // LAUNCH is ignored while RED is lit.
          if (YELLOW) begin
            if (LAUNCH) begin
              foul_n  = 1'b1;
              state_n = LOCKOUT;
            end else begin
              state_n = ARMED;
            end
          end else if (GREEN) begin
            seq_err_n = 1'b1;
            state_n   = LOCKOUT;
          end
        end
        ARMED: begin
          if (YELLOW) begin
            if (LAUNCH) begin
              foul_n  = 1'b1;
              state_n = LOCKOUT;
            end
          end else if (GREEN) begin
            if (LAUNCH) begin
              reaction_n = '0;
              valid_n    = 1'b1;
              state_n    = LOCKOUT;
            end else begin
              // The first GREEN edge counts as 0, so the next edge sees 1.
              cnt_n   = CNT_W'(1);
              state_n = TIMING;
            end
          end else begin
            // RED before GREEN: the sequence was aborted.
            seq_err_n = 1'b1;
            state_n   = LOCKOUT;
          end
        end
        TIMING: begin
          // GREEN or RED both keep timing, because green may end early.
          if (YELLOW) begin
            seq_err_n = 1'b1;
            state_n   = LOCKOUT;
          end else if (LAUNCH) begin
            reaction_n = cnt;
            valid_n    = 1'b1;
            state_n    = LOCKOUT;
          end else if (cnt == CNT_W'(MAX_REACT)) begin
            timeout_n = 1'b1;
            state_n   = LOCKOUT;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        LOCKOUT: begin
          // Rearm only on a clean RED with LAUNCH released. lamps_legal
          // already guarantees that YELLOW and GREEN are low here.
          if (RED && !LAUNCH) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      REACTION <= '0;
      VALID    <= 1'b0;
      FOUL     <= 1'b0;
      TIMEOUT  <= 1'b0;
      SEQ_ERR  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      REACTION <= reaction_n;
      VALID    <= valid_n;
      FOUL     <= foul_n;
      TIMEOUT  <= timeout_n;
      SEQ_ERR  <= seq_err_n;
    end
  end

  assign STATE_DBG = state;

endmodule
